// File: rtl/fsm_onehot_next_pkg.sv
// ---------------------------------------------------------------------------
// fsm_onehot_next_pkg
// Purpose : shared constants for the timer/serial-command controller one-hot
//           FSM decoder: state vector width, fixed state bit indices and a
//           helper that tests a state vector for exactly-one-hot.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package fsm_onehot_next_pkg;

  localparam int unsigned STATE_W = 10;

  // Fixed bit positions of each state inside the one-hot vector
  localparam int unsigned S_IDX     = 0;
  localparam int unsigned S1_IDX    = 1;
  localparam int unsigned S11_IDX   = 2;
  localparam int unsigned S110_IDX  = 3;
  localparam int unsigned B0_IDX    = 4;
  localparam int unsigned B1_IDX    = 5;
  localparam int unsigned B2_IDX    = 6;
  localparam int unsigned B3_IDX    = 7;
  localparam int unsigned COUNT_IDX = 8;
  localparam int unsigned WAIT_IDX  = 9;

  typedef logic [STATE_W-1:0] state_vec_t;

  // True when exactly one bit is set: non-zero and clearing the lowest set
  // bit leaves nothing behind.
  function automatic logic is_onehot(input state_vec_t vec);
    state_vec_t low_cleared;
    low_cleared = vec & (vec - STATE_W'(1));
    return (vec != '0) && (low_cleared == '0);
  endfunction

endpackage : fsm_onehot_next_pkg

// File: rtl/fsm_onehot_next_if.sv
// ---------------------------------------------------------------------------
// fsm_onehot_next_if
// Purpose : groups the decoder's data-path signals between the parent FSM
//           (master) and the next-state/output decoder (slave).
// Signals : d, done_counting, ack, state        master -> slave
//           B3_next, S_next, S1_next, Count_next,
//           Wait_next, done, counting, shift_ena,
//           onehot_err                          slave -> master
// ---------------------------------------------------------------------------
interface fsm_onehot_next_if;
  import fsm_onehot_next_pkg::*;

  logic       d;
  logic       done_counting;
  logic       ack;
  state_vec_t state;

  logic       B3_next;
  logic       S_next;
  logic       S1_next;
  logic       Count_next;
  logic       Wait_next;
  logic       done;
  logic       counting;
  logic       shift_ena;
  logic       onehot_err;

  modport master (
    output d, done_counting, ack, state,
    input  B3_next, S_next, S1_next, Count_next, Wait_next,
           done, counting, shift_ena, onehot_err
  );

  modport slave (
    input  d, done_counting, ack, state,
    output B3_next, S_next, S1_next, Count_next, Wait_next,
           done, counting, shift_ena, onehot_err
  );

endinterface : fsm_onehot_next_if

// File: rtl/fsm_onehot_next.sv
// ---------------------------------------------------------------------------
// fsm_onehot_next
// Purpose : combinational next-state and Moore-output decoder for the 10-state
//           one-hot controller FSM (detect 1101, shift 4 bits, count, wait for
//           ack). The state register lives in the parent. A registered sticky
//           diagnostic flags any cycle where the state vector is not one-hot.
// Ports   : clk      in  system clock, only clocks the diagnostic flag
//           rst_n    in  synchronous active-low reset, clears onehot_err
//           bus      slave modport: d, done_counting, ack, state in;
//                    B3_next, S_next, S1_next, Count_next, Wait_next,
//                    done, counting, shift_ena, onehot_err out
// ---------------------------------------------------------------------------
module fsm_onehot_next
  import fsm_onehot_next_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  fsm_onehot_next_if.slave    bus
);

  state_vec_t st;
  logic       onehot_err_d;
  logic       onehot_err_q;

  assign st = bus.state;

  // Next-state bits: plain sum-of-products over every state bit, so the
  // result is well defined for zero-hot and multi-hot vectors as well.
  always_comb begin
    bus.B3_next    = st[B2_IDX];
    bus.S_next     = ((st[S_IDX] | st[S1_IDX] | st[S110_IDX]) & ~bus.d)
                   | (st[WAIT_IDX] & bus.ack);
    bus.S1_next    = st[S_IDX] & bus.d;
    bus.Count_next = st[B3_IDX] | (st[COUNT_IDX] & ~bus.done_counting);
    bus.Wait_next  = (st[COUNT_IDX] & bus.done_counting)
                   | (st[WAIT_IDX] & ~bus.ack);
  end

  // Moore outputs
  always_comb begin
    bus.done      = st[WAIT_IDX];
    bus.counting  = st[COUNT_IDX];
    bus.shift_ena = |st[B3_IDX:B0_IDX];
  end

  // Sticky flag: once a non-one-hot vector is seen it holds until reset
  always_comb begin
    onehot_err_d = onehot_err_q | ~is_onehot(st);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      onehot_err_q <= 1'b0;
    end else begin
      onehot_err_q <= onehot_err_d;
    end
  end

  assign bus.onehot_err = onehot_err_q;

endmodule : fsm_onehot_next

// File: tb/tb_fsm_onehot_next.sv
// ---------------------------------------------------------------------------
// tb_fsm_onehot_next
// Purpose : self-checking bench for fsm_onehot_next. Expected decode values
//           come from a per-state transition model OR-ed over all set bits.
// ---------------------------------------------------------------------------
module tb_fsm_onehot_next;

  logic clk;
  logic rst_n;

  int unsigned n_vec;
  int unsigned n_err;

  fsm_onehot_next_if bus_if ();

  fsm_onehot_next dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed decode: {B3_next,S_next,S1_next,Count_next,Wait_next,done,counting,shift_ena}
  function automatic logic [7:0] observed();
    return {bus_if.B3_next, bus_if.S_next, bus_if.S1_next, bus_if.Count_next,
            bus_if.Wait_next, bus_if.done, bus_if.counting, bus_if.shift_ena};
  endfunction

  // Reference model: each active state contributes its own FSM transition
  function automatic logic [7:0] model(input logic [9:0] st, input logic d,
                                       input logic dc, input logic ack);
    logic b3, s, s1, cn, w;
    b3 = 1'b0; s = 1'b0; s1 = 1'b0; cn = 1'b0; w = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (st[i]) begin
        case (i)
          0: if (d) s1 = 1'b1; else s = 1'b1;
          1: if (!d) s = 1'b1;
          3: if (!d) s = 1'b1;
          6: b3 = 1'b1;
          7: cn = 1'b1;
          8: if (dc) w = 1'b1; else cn = 1'b1;
          9: if (ack) s = 1'b1; else w = 1'b1;
          default: ;
        endcase
      end
    end
    return {b3, s, s1, cn, w, st[9], st[8], |st[7:4]};
  endfunction

  task automatic apply(input logic [9:0] st, input logic d, input logic dc,
                       input logic ack);
    bus_if.state         = st;
    bus_if.d             = d;
    bus_if.done_counting = dc;
    bus_if.ack           = ack;
    #1;
  endtask

  initial begin
    logic [9:0] st;
    logic [2:0] in3;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    apply(10'h001, 1'b0, 1'b0, 1'b0);

    // Reset clears the diagnostic flag
    @(posedge clk); #1;
    check_eq("reset_err", 32'(bus_if.onehot_err), 32'd0);

    // One-hot sweep over all input combinations
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 8; c++) begin
        st  = 10'(1) << i;
        in3 = 3'(c);
        apply(st, in3[2], in3[1], in3[0]);
        check_eq($sformatf("sweep_s%0d_c%0d", i, c), 32'(observed()),
                 32'(model(st, in3[2], in3[1], in3[0])));
      end
    end

    // Directed hand-computed cases
    apply(10'h001, 1'b1, 1'b0, 1'b0);
    check_eq("s_d1", 32'(observed()), 32'h20);
    apply(10'h200, 1'b0, 1'b0, 1'b1);
    check_eq("wait_ack1", 32'(observed()), 32'h44);
    apply(10'h200, 1'b0, 1'b0, 1'b0);
    check_eq("wait_ack0", 32'(observed()), 32'h0C);
    apply(10'h100, 1'b0, 1'b1, 1'b0);
    check_eq("count_dc1", 32'(observed()), 32'h0A);
    apply(10'h040, 1'b0, 1'b0, 1'b0);
    check_eq("b2_shift", 32'(observed()), 32'h81);
    apply(10'h080, 1'b0, 1'b0, 1'b0);
    check_eq("b3_shift", 32'(observed()), 32'h11);
    apply(10'h3FF, 1'b1, 1'b1, 1'b1);
    check_eq("all_hot", 32'(observed()), 32'hFF);
    apply(10'h209, 1'b0, 1'b0, 1'b1);
    check_eq("mh_209_snext", 32'(bus_if.S_next), 32'd1);
    apply(10'h000, 1'b1, 1'b1, 1'b1);
    check_eq("zero_hot", 32'(observed()), 32'h00);

    // Random multi-hot vectors
    for (int k = 0; k < 3000; k++) begin
      st  = 10'($urandom);
      in3 = 3'($urandom);
      apply(st, in3[2], in3[1], in3[0]);
      check_eq($sformatf("rand_%0d", k), 32'(observed()),
               32'(model(st, in3[2], in3[1], in3[0])));
    end

    // Diagnostic checker: valid one-hot keeps flag low after reset release
    @(negedge clk);
    rst_n = 1'b0;
    apply(10'h010, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_eq("err_after_rst", 32'(bus_if.onehot_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("err_valid", 32'(bus_if.onehot_err), 32'd0);

    @(negedge clk); bus_if.state = 10'h000;
    @(posedge clk); #1;
    check_eq("err_zero_hot", 32'(bus_if.onehot_err), 32'd1);
    @(negedge clk); bus_if.state = 10'h004;
    @(posedge clk); #1;
    check_eq("err_sticky", 32'(bus_if.onehot_err), 32'd1);

    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("err_cleared", 32'(bus_if.onehot_err), 32'd0);
    @(negedge clk); rst_n = 1'b1; bus_if.state = 10'h003;
    @(posedge clk); #1;
    check_eq("err_multi_hot", 32'(bus_if.onehot_err), 32'd1);
    @(negedge clk); bus_if.state = 10'h100;
    @(posedge clk); #1;
    check_eq("err_sticky2", 32'(bus_if.onehot_err), 32'd1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("err_cleared2", 32'(bus_if.onehot_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fsm_onehot_next
